// File: rtl/icu_pkg.sv
// Shared constants for the interrupt control unit: register offsets and data-bus modes.
package icu_pkg;

    localparam logic [7:0] ICU_MASK     = 8'h00;
    localparam logic [7:0] ICU_FLAGS    = 8'h04;
    localparam logic [7:0] ICU_ACT_IDX  = 8'h08;
    localparam logic [7:0] ICU_ACT_FLAG = 8'h0C;
    localparam logic [7:0] ICU_MODE     = 8'h10;
    localparam logic [7:0] ICU_CTRL     = 8'h14;

    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one active-low interrupt line, plus a history flop
// so the caller can choose between the asserted level and its rising edge.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_n,
    output logic level,
    output logic rise
);

    logic ff1;
    logic ff2;
    logic s_prev;

    // Chains reset to the inactive (high) pin state so no spurious edge appears after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff1    <= 1'b1;
            ff2    <= 1'b1;
            s_prev <= 1'b0;
        end else begin
            ff1    <= irq_n;
            ff2    <= ff1;
            s_prev <= ~ff2;
        end
    end

    assign level = ~ff2;
    assign rise  = level & ~s_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt control unit: synchronised sources, pending flags, fixed lowest-index
// priority, memory-mapped registers and the PC redirect for ISR entry and RETI.
module irq_controller
    import icu_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h4000,
    parameter logic [31:0] FIXED_VECTOR  = 32'h10,
    parameter int          VECTOR_STRIDE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_sources,
    input  logic [31:0]        slv_address,
    input  logic [31:0]        slv_write_data,
    input  logic [1:0]         slv_mode,
    input  logic               slv_select,
    output logic [31:0]        slv_read_data,
    input  logic [31:0]        pc_next,
    input  logic               stall,
    input  logic               halt,
    input  logic               end_isr,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               in_isr
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] level;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] hit;
    logic [NUM_IRQ-1:0] flags;
    logic [NUM_IRQ-1:0] new_flags;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] clear;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] active_flag;
    logic [IDX_W-1:0]   active_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               vec_en;
    logic [23:0]        vec_base;
    logic [31:0]        ipc;
    logic [31:0]        entry_pc;
    logic [31:0]        offset;
    logic               trig;
    logic               reti;
    logic               bus_wr;
    logic               bus_rd;
    logic               unused_wdata;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .irq_n (irq_sources[gi]),
            .level (level[gi]),
            .rise  (rise[gi])
        );
    end

    assign hit       = (mode & rise) | (~mode & level);
    assign new_flags = flags | hit;
    assign pending   = new_flags & mask;
    assign win_idx   = lowest_idx(pending);
    assign trig      = (|pending) & ~in_isr & ~stall & ~halt;
    assign reti      = end_isr & in_isr & ~stall & ~halt;

    assign offset       = slv_address - BASE_ADDR;
    assign bus_wr       = slv_select && (slv_mode == BUS_WRITE);
    assign bus_rd       = slv_select && (slv_mode == BUS_READ);
    assign clear        = (bus_wr && offset == 32'(ICU_FLAGS)) ? slv_write_data[NUM_IRQ-1:0] : '0;
    assign unused_wdata = ^slv_write_data;

    assign entry_pc = vec_en ? ({vec_base, 8'h00} + (32'(win_idx) * 32'(VECTOR_STRIDE)))
                             : FIXED_VECTOR;

    // Trigger and RETI are mutually exclusive because trig requires in_isr low.
    always_comb begin
        redirect    = trig | reti;
        redirect_pc = '0;
        if (reti)      redirect_pc = ipc;
        else if (trig) redirect_pc = entry_pc;
    end

    // Clearing happens before the OR so a hit arriving with a W1C still sets the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags       <= '0;
            mask        <= '0;
            mode        <= '0;
            vec_en      <= 1'b0;
            vec_base    <= '0;
            ipc         <= '0;
            in_isr      <= 1'b0;
            active_idx  <= '0;
            active_flag <= '0;
        end else begin
            flags <= (flags & ~clear) | hit;
            if (bus_wr) begin
                case (offset)
                    32'(ICU_MASK): mask <= slv_write_data[NUM_IRQ-1:0];
                    32'(ICU_MODE): mode <= slv_write_data[NUM_IRQ-1:0];
                    32'(ICU_CTRL): begin
                        vec_en   <= slv_write_data[0];
                        vec_base <= slv_write_data[31:8];
                    end
                    default: ;
                endcase
            end
            if (trig) begin
                ipc         <= pc_next;
                in_isr      <= 1'b1;
                active_idx  <= win_idx;
                active_flag <= NUM_IRQ'(1) << win_idx;
            end else if (reti) begin
                in_isr <= 1'b0;
            end
        end
    end

    always_comb begin
        slv_read_data = '0;
        if (bus_rd) begin
            case (offset)
                32'(ICU_MASK):     slv_read_data = 32'(mask);
                32'(ICU_FLAGS):    slv_read_data = 32'(flags);
                32'(ICU_ACT_IDX):  slv_read_data = 32'(active_idx);
                32'(ICU_ACT_FLAG): slv_read_data = 32'(active_flag);
                32'(ICU_MODE):     slv_read_data = 32'(mode);
                32'(ICU_CTRL):     slv_read_data = {vec_base, 7'b0, vec_en};
                default:           slv_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected redirect targets are queued when
// an interrupt or RETI is provoked and compared when the DUT raises redirect.
module tb_irq_controller;
    import icu_pkg::*;

    localparam logic [31:0] BASE = 32'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_sources;
    logic [31:0] slv_address;
    logic [31:0] slv_write_data;
    logic [1:0]  slv_mode;
    logic        slv_select;
    logic [31:0] slv_read_data;
    logic [31:0] pc_next;
    logic        stall;
    logic        halt;
    logic        end_isr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        in_isr;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    irq_controller dut (
        .clk            (clk),
        .reset          (reset),
        .irq_sources    (irq_sources),
        .slv_address    (slv_address),
        .slv_write_data (slv_write_data),
        .slv_mode       (slv_mode),
        .slv_select     (slv_select),
        .slv_read_data  (slv_read_data),
        .pc_next        (pc_next),
        .stall          (stall),
        .halt           (halt),
        .end_isr        (end_isr),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .in_isr         (in_isr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
        @(posedge clk);
        #1;
        slv_select     = 1'b1;
        slv_mode       = BUS_WRITE;
        slv_address    = BASE + 32'(off);
        slv_write_data = data;
        @(posedge clk);
        #1;
        slv_select = 1'b0;
        slv_mode   = 2'b00;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
        @(posedge clk);
        #1;
        slv_select  = 1'b1;
        slv_mode    = BUS_READ;
        slv_address = BASE + 32'(off);
        @(negedge clk);
        data = slv_read_data;
        #1;
        slv_select = 1'b0;
        slv_mode   = 2'b00;
    endtask

    task automatic wait_redirect(input int max, output bit found, output int cycles,
                                 output logic [31:0] pc);
        found  = 1'b0;
        cycles = -1;
        pc     = '0;
        for (int n = 0; n < max && !found; n++) begin
            @(negedge clk);
            if (redirect === 1'b1) begin
                found  = 1'b1;
                cycles = n;
                pc     = redirect_pc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        total++;
        if (redirect !== 1'b0 || in_isr !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b/%b/%h want=0/0/0", redirect, in_isr, redirect_pc);
        end
        reset = 1'b1;
        begin
            logic [31:0] rd;
            bus_read(ICU_FLAGS, rd);
            total++;
            if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_flags got=%h want=0", rd); end
            bus_read(ICU_CTRL, rd);
            total++;
            if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_ctrl got=%h want=0", rd); end
            bus_read(8'h18, rd);
            total++;
            if (rd !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_read got=%h want=0", rd); end
        end
        tick(1);
        end_isr = 1'b1;
        @(negedge clk);
        total++;
        if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL reti_idle got=%b want=0", redirect); end
        tick(1);
        end_isr = 1'b0;
    endtask

    task automatic do_reti(input logic [31:0] ipc_exp, input string name);
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        exp_q.push_back(ipc_exp);
        end_isr = 1'b1;
        wait_redirect(2, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp) begin
            bad++;
            $display("[TB] FAIL %s_pc got=%h want=%h", name, pc, exp);
        end
        tick(1);
        end_isr = 1'b0;
        total++;
        if (in_isr !== 1'b0) begin bad++; $display("[TB] FAIL %s_exit got=%b want=0", name, in_isr); end
    endtask

    task automatic test_level();
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        logic [31:0] rd;
        bus_write(ICU_MASK, 32'h5);
        pc_next = 32'h100;
        exp_q.push_back(32'h10);
        irq_sources[2] = 1'b0;
        wait_redirect(10, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp || cyc != 2) begin
            bad++;
            $display("[TB] FAIL level_entry got=%h@%0d want=%h@2", pc, cyc, exp);
        end
        tick(1);
        total++;
        if (in_isr !== 1'b1) begin bad++; $display("[TB] FAIL level_in_isr got=%b want=1", in_isr); end
        bus_read(ICU_ACT_IDX, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("[TB] FAIL level_act_idx got=%h want=2", rd); end
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h4) begin bad++; $display("[TB] FAIL level_flags got=%h want=4", rd); end
        irq_sources = 4'hF;
        tick(3);
        bus_write(ICU_FLAGS, 32'hF);
        do_reti(32'h100, "level_reti");
        @(negedge clk);
        total++;
        if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL level_idle got=%b want=0", redirect); end
    endtask

    task automatic test_priority();
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        logic [31:0] rd;
        bus_write(ICU_MASK, 32'hF);
        pc_next = 32'h200;
        exp_q.push_back(32'h10);
        irq_sources = 4'b0101;
        wait_redirect(10, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp) begin bad++; $display("[TB] FAIL prio_entry got=%h want=%h", pc, exp); end
        tick(1);
        bus_read(ICU_ACT_IDX, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("[TB] FAIL prio_act_idx got=%h want=1", rd); end
        bus_read(ICU_ACT_FLAG, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("[TB] FAIL prio_act_flag got=%h want=2", rd); end
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'hA) begin bad++; $display("[TB] FAIL prio_flags got=%h want=a", rd); end
        irq_sources = 4'hF;
        tick(3);
        bus_write(ICU_FLAGS, 32'hF);
        do_reti(32'h200, "prio_reti");
    endtask

    task automatic test_vectored_edge();
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        logic [31:0] rd;
        bus_write(ICU_CTRL, 32'h0000_2001);
        bus_write(ICU_MODE, 32'h8);
        bus_write(ICU_MASK, 32'h8);
        bus_read(ICU_CTRL, rd);
        total++;
        if (rd !== 32'h2001) begin bad++; $display("[TB] FAIL vec_ctrl got=%h want=2001", rd); end
        pc_next = 32'h300;
        exp_q.push_back(32'h2030);
        tick(1);
        irq_sources[3] = 1'b0;
        wait_redirect(10, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp || cyc != 2) begin
            bad++;
            $display("[TB] FAIL vec_entry got=%h@%0d want=%h@2", pc, cyc, exp);
        end
        tick(1);
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h8) begin bad++; $display("[TB] FAIL edge_first got=%h want=8", rd); end
        bus_write(ICU_FLAGS, 32'h8);
        tick(2);
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL edge_held_low got=%h want=0", rd); end
        irq_sources[3] = 1'b1;
        tick(3);
        irq_sources[3] = 1'b0;
        tick(4);
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h8) begin bad++; $display("[TB] FAIL edge_second got=%h want=8", rd); end
        irq_sources[3] = 1'b1;
        tick(3);
        bus_write(ICU_FLAGS, 32'hF);
        do_reti(32'h300, "vec_reti");
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus_write(ICU_MASK, 32'h0);
        bus_write(ICU_MODE, 32'h1);
        irq_sources[0] = 1'b0;
        tick(2);
        slv_select     = 1'b1;
        slv_mode       = BUS_WRITE;
        slv_address    = BASE + 32'(ICU_FLAGS);
        slv_write_data = 32'h1;
        tick(1);
        slv_select = 1'b0;
        slv_mode   = 2'b00;
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h1) begin bad++; $display("[TB] FAIL w1c_collision got=%h want=1", rd); end
        bus_write(ICU_FLAGS, 32'h1);
        bus_read(ICU_FLAGS, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL w1c_plain got=%h want=0", rd); end
        irq_sources[0] = 1'b1;
        tick(3);
    endtask

    task automatic test_stall_halt();
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        bus_write(ICU_CTRL, 32'h0);
        bus_write(ICU_MODE, 32'h0);
        bus_write(ICU_MASK, 32'h1);
        pc_next = 32'h400;
        stall   = 1'b1;
        irq_sources[0] = 1'b0;
        tick(5);
        @(negedge clk);
        total++;
        if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL stall_block got=%b want=0", redirect); end
        tick(1);
        stall = 1'b0;
        halt  = 1'b1;
        @(negedge clk);
        total++;
        if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL halt_block got=%b want=0", redirect); end
        tick(1);
        halt = 1'b0;
        exp_q.push_back(32'h10);
        wait_redirect(3, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp || cyc != 0) begin
            bad++;
            $display("[TB] FAIL release_entry got=%h@%0d want=%h@0", pc, cyc, exp);
        end
        tick(1);
        total++;
        if (in_isr !== 1'b1) begin bad++; $display("[TB] FAIL release_in_isr got=%b want=1", in_isr); end
    endtask

    task automatic test_reti_pending();
        bit          found;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] exp;
        logic [31:0] rd;
        pc_next = 32'h500;
        do_reti(32'h400, "pend_reti");
        exp_q.push_back(32'h10);
        wait_redirect(1, found, cyc, pc);
        exp = exp_q.pop_front();
        total++;
        if (!found || pc !== exp) begin bad++; $display("[TB] FAIL pend_retrigger got=%h want=%h", pc, exp); end
        tick(1);
        total++;
        if (in_isr !== 1'b1) begin bad++; $display("[TB] FAIL pend_in_isr got=%b want=1", in_isr); end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (in_isr !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%b/%b/%h want=0/0/0", in_isr, redirect, redirect_pc);
        end
        bus_read(ICU_MASK, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_mask got=%h want=0", rd); end
        reset = 1'b1;
        irq_sources = 4'hF;
        tick(2);
    endtask

    initial begin
        reset          = 1'b0;
        irq_sources    = 4'hF;
        slv_address    = '0;
        slv_write_data = '0;
        slv_mode       = 2'b00;
        slv_select     = 1'b0;
        pc_next        = '0;
        stall          = 1'b0;
        halt           = 1'b0;
        end_isr        = 1'b0;
        test_reset();
        test_level();
        test_priority();
        test_vectored_edge();
        test_w1c_collision();
        test_stall_halt();
        test_reti_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
